int_to_float: RTL and testbench

- Iterative integer to IEEE-754 single-precision converter. It is the producer side of the float format that the integrality checker consumes.
- Accepts a 32-bit integer through a valid/ready handshake.
- Normalizes the value by shifting left one bit per clock, then rounds to nearest-even.
- Returns the 32-bit float plus an exactness flag through a second valid/ready handshake.

---
 rtl/int_to_float.sv | 100 ++++++++++
 tb/tb_int_to_float.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/int_to_float.sv
// Iterative int32 -> IEEE-754 single converter; lz+2 cycles (1 for zero) from accept to out_valid.
// One conversion in flight: in_ready only in IDLE, result held stable in DONE until out_ready.
module int_to_float #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] num,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        exact
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state;
  logic        sign;
  logic [31:0] mag;
  logic [7:0]  exp;

  logic        capt_sign;
  logic [31:0] capt_mag;
  logic [22:0] m;
  logic        guard;
  logic        sticky;
  logic        up;
  logic [23:0] m_sum;
  logic [22:0] mant_rnd;
  logic [7:0]  exp_rnd;

  assign in_ready  = (state == IDLE);
  assign capt_sign = SIGNED & num[31];
  // -2^31 negates to itself, which is the correct unsigned magnitude
  assign capt_mag  = capt_sign ? (~num + 32'd1) : num;

  assign m        = mag[30:8];
  assign guard    = mag[7];
  assign sticky   = |mag[6:0];
  assign up       = guard & (sticky | m[0]);
  assign m_sum    = {1'b0, m} + {23'd0, up};
  assign mant_rnd = m_sum[23] ? 23'd0 : m_sum[22:0];
  assign exp_rnd  = exp + {7'd0, m_sum[23]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sign      <= 1'b0;
      mag       <= 32'd0;
      exp       <= 8'd0;
      out_valid <= 1'b0;
      res       <= 32'd0;
      exact     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign <= capt_sign;
            mag  <= capt_mag;
            exp  <= 8'd158;
            if (capt_mag == 32'd0) begin
              res   <= 32'd0;
              exact <= 1'b1;
              state <= DONE;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
          if (mag[31]) begin
            state <= ROUND;
          end else begin
            mag <= mag << 1;
            exp <= exp - 8'd1;
          end
        end
        ROUND: begin
          res       <= {sign, exp_rnd, mant_rnd};
          exact     <= ~(guard | sticky);
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          // zero path enters with out_valid low; it rises one cycle later
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_float.sv
// Directed bench for int_to_float: signed and unsigned instances share num/out_ready/rst.
module tb_int_to_float;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_s, in_valid_u;
  logic [31:0] num;
  logic        out_ready;

  logic        s_in_ready, s_out_valid, s_exact;
  logic [31:0] s_res;
  logic        u_in_ready, u_out_valid, u_exact;
  logic [31:0] u_res;

  logic        cur;
  logic        o_ready, o_valid, o_exact;
  logic [31:0] o_res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_to_float #(.SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(s_in_ready), .num(num),
    .out_valid(s_out_valid), .out_ready(out_ready), .res(s_res), .exact(s_exact)
  );

  int_to_float #(.SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid_u), .in_ready(u_in_ready), .num(num),
    .out_valid(u_out_valid), .out_ready(out_ready), .res(u_res), .exact(u_exact)
  );

  assign o_ready = cur ? u_in_ready  : s_in_ready;
  assign o_valid = cur ? u_out_valid : s_out_valid;
  assign o_exact = cur ? u_exact     : s_exact;
  assign o_res   = cur ? u_res       : s_res;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (o_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // sel: 0 = signed instance, 1 = unsigned instance; elat counted in edges after accept
  task automatic convert(input logic sel, input logic [31:0] n, input logic [31:0] er,
                         input logic ee, input int elat, input string tag);
    int lat;
    cur = sel;
    #0;
    chk({tag, " in_ready"}, {31'd0, o_ready}, 32'd1);
    num        = n;
    in_valid_s = !sel;
    in_valid_u = sel;
    out_ready  = 1'b1;
    @(posedge clk); #1;
    in_valid_s = 1'b0;
    in_valid_u = 1'b0;
    wait_valid(lat);
    chk({tag, " latency"}, lat, elat);
    chk({tag, " res"}, o_res, er);
    chk({tag, " exact"}, {31'd0, o_exact}, {31'd0, ee});
    @(posedge clk); #1;
    chk({tag, " out_valid_drop"}, {31'd0, o_valid}, 32'd0);
    chk({tag, " in_ready_back"}, {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    cur        = 1'b0;
    rst        = 1'b1;
    in_valid_s = 1'b0;
    in_valid_u = 1'b0;
    num        = 32'd0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst s_in_ready", {31'd0, s_in_ready}, 32'd1);
    chk("rst s_out_valid", {31'd0, s_out_valid}, 32'd0);
    chk("rst s_res", s_res, 32'd0);
    chk("rst s_exact", {31'd0, s_exact}, 32'd0);
    chk("rst u_out_valid", {31'd0, u_out_valid}, 32'd0);
    chk("rst u_res", u_res, 32'd0);

    convert(1'b0, 32'h0000_0001, 32'h3F80_0000, 1'b1, 33, "s_one");
    convert(1'b0, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b1, 33, "s_minus_one");
    convert(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1,  "s_zero");
    convert(1'b0, 32'h8000_0000, 32'hCF00_0000, 1'b1, 2,  "s_int_min");
    convert(1'b0, 32'h0100_0001, 32'h4B80_0000, 1'b0, 9,  "tie_even_down");
    convert(1'b0, 32'h0100_0003, 32'h4B80_0002, 1'b0, 9,  "tie_odd_up");
    convert(1'b0, 32'h7FFF_FFFF, 32'h4F00_0000, 1'b0, 3,  "mant_carry");
    convert(1'b1, 32'hFFFF_FFFF, 32'h4F80_0000, 1'b0, 2,  "u_max");
    convert(1'b1, 32'h8000_0000, 32'h4F00_0000, 1'b1, 2,  "u_msb");

    // backpressure: result held while out_ready low, input pulses ignored
    cur        = 1'b0;
    num        = 32'd5;
    out_ready  = 1'b0;
    in_valid_s = 1'b1;
    @(posedge clk); #1;
    in_valid_s = 1'b0;
    wait_valid(lat);
    chk("bp latency", lat, 31);
    chk("bp res", s_res, 32'h40A0_0000);
    for (int i = 0; i < 10; i++) begin
      num        = 32'd123 + i;
      in_valid_s = i[0];
      @(posedge clk); #1;
      chk("bp hold out_valid", {31'd0, s_out_valid}, 32'd1);
      chk("bp hold res", s_res, 32'h40A0_0000);
      chk("bp hold exact", {31'd0, s_exact}, 32'd1);
      chk("bp hold in_ready", {31'd0, s_in_ready}, 32'd0);
    end
    in_valid_s = 1'b0;
    out_ready  = 1'b1;
    @(posedge clk); #1;
    chk("bp release out_valid", {31'd0, s_out_valid}, 32'd0);
    chk("bp release in_ready", {31'd0, s_in_ready}, 32'd1);
    chk("bp res kept", s_res, 32'h40A0_0000);

    // reset mid-normalisation drops the conversion
    num        = 32'd1;
    in_valid_s = 1'b1;
    @(posedge clk); #1;
    in_valid_s = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_norm busy", {31'd0, s_in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst in_ready", {31'd0, s_in_ready}, 32'd1);
    chk("mid_rst out_valid", {31'd0, s_out_valid}, 32'd0);
    chk("mid_rst res", s_res, 32'd0);
    chk("mid_rst exact", {31'd0, s_exact}, 32'd0);
    convert(1'b0, 32'd3, 32'h4040_0000, 1'b1, 32, "after_rst_three");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
